// File: rtl/a2d_resp.sv
// SPI responder modelling a 12-bit, 8-channel A2D converter on the far side of the SPI link.
// Optional sticky framing-error flag (err port) enabled by defining A2D_RESP_ERR_EN.
module a2d_resp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] res,
  output logic [2:0]  chnnl,
  output logic        trans_done
`ifdef A2D_RESP_ERR_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, CONV} state_t;

  state_t      state, state_nxt;
  logic [2:0]  ss_sync, sclk_sync, mosi_sync;
  logic        ss_fall, ss_rise, sclk_rise, sclk_fall, ss_low;
  logic [15:0] tx;
  logic [13:0] rx;
  logic [4:0]  cnt;
  logic [11:0] shadow;
  logic        pend;
  logic        load_tx, shift_rx, shift_tx, do_commit, do_capture;
  logic        set_pend, clr_pend, frame_err;

  // Sync flops reset to the idle level of each line so reset release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync   <= 3'b111;
      sclk_sync <= 3'b111;
      mosi_sync <= 3'b000;
    end else begin
      ss_sync   <= {ss_sync[1:0], SS_n};
      sclk_sync <= {sclk_sync[1:0], SCLK};
      mosi_sync <= {mosi_sync[1:0], MOSI};
    end
  end

  assign ss_low    = ~ss_sync[1];
  assign ss_fall   = ss_sync[2] & ~ss_sync[1];
  assign ss_rise   = ~ss_sync[2] & ss_sync[1];
  assign sclk_rise = ~sclk_sync[2] & sclk_sync[1];
  assign sclk_fall = sclk_sync[2] & ~sclk_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_tx    = 1'b0;
    shift_rx   = 1'b0;
    shift_tx   = 1'b0;
    do_commit  = 1'b0;
    do_capture = 1'b0;
    set_pend   = 1'b0;
    clr_pend   = 1'b0;
    frame_err  = 1'b0;
    trans_done = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall || pend) begin
          load_tx   = 1'b1;
          clr_pend  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_rx  = sclk_rise;
        // The leading SCLK fall after SS_n must not shift away bit 15.
        shift_tx  = sclk_fall && (cnt != 5'd0);
        frame_err = ss_fall;
        if (ss_rise) begin
          if (cnt == 5'd16) begin
            state_nxt = COMMIT;
          end else begin
            frame_err = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      COMMIT: begin
        do_commit = 1'b1;
        set_pend  = ss_fall;
        state_nxt = CONV;
      end
      CONV: begin
        do_capture = 1'b1;
        trans_done = 1'b1;
        set_pend   = ss_fall;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx     <= '0;
      rx     <= '0;
      cnt    <= '0;
      chnnl  <= '0;
      shadow <= '0;
      pend   <= 1'b0;
    end else begin
      if (load_tx) begin
        tx  <= {4'b0000, shadow};
        cnt <= '0;
      end else begin
        if (shift_tx) tx <= {tx[14:0], 1'b0};
        if (shift_rx) begin
          rx  <= {rx[12:0], mosi_sync[1]};
          cnt <= (cnt == 5'd31) ? cnt : cnt + 5'd1;
        end
      end
      if (do_commit)  chnnl  <= rx[13:11];
      // res follows chnnl, so capturing one cycle after commit picks up the new channel.
      if (do_capture) shadow <= res;
      if (set_pend)      pend <= 1'b1;
      else if (clr_pend) pend <= 1'b0;
    end
  end

  assign MISO = tx[15] & ss_low;

`ifdef A2D_RESP_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err <= 1'b0;
    else if (frame_err) err <= 1'b1;
  end
`else
  logic unused_err;
  assign unused_err = frame_err;
`endif

endmodule

// File: tb/tb_a2d_resp.sv
// Directed self-checking bench for a2d_resp: SPI master model with 16-clk SCLK phases.
module tb_a2d_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ss_n = 1'b1;
  logic        sclk = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [11:0] res;
  logic [2:0]  chnnl;
  logic        trans_done;
  logic        res_mode = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          td_cnt = 0;
`ifdef A2D_RESP_ERR_EN
  logic        err;
`endif

  a2d_resp dut (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi), .MISO(miso),
    .res(res), .chnnl(chnnl), .trans_done(trans_done)
`ifdef A2D_RESP_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    if (res_mode) res = {9'b0, chnnl} + 12'h100;
    else          res = (chnnl != 3'd0) ? 12'hA5C : 12'h123;
  end

  always @(posedge clk) if (trans_done === 1'b1) td_cnt++;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_frame(input logic [15:0] cmd, input int nrise, input bit raise_ss,
                           output logic [15:0] word);
    word = '0;
    @(negedge clk);
    ss_n = 1'b0;
    idle(16);
    for (int i = 0; i < nrise; i++) begin
      sclk = 1'b0;
      mosi = (i < 16) ? cmd[15 - i] : 1'b0;
      idle(16);
      sclk = 1'b1;
      word = {word[14:0], miso};
      idle(16);
    end
    if (raise_ss) ss_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sclk = ~sclk;
      ss_n = ~ss_n;
    end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got=%b exp=0", miso); end
    checks++; if (chnnl !== 3'd0) begin errors++; $display("FAIL reset_chnnl got=%0d exp=0", chnnl); end
    checks++; if (td_cnt !== 0) begin errors++; $display("FAIL reset_trans_done got=%0d exp=0", td_cnt); end
`ifdef A2D_RESP_ERR_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
`endif
    ss_n = 1'b1;
    sclk = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(4);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL idle_miso got=%b exp=0", miso); end
  endtask

  task automatic test_two_frame;
    logic [15:0] w;
    res_mode = 1'b0;
    td_cnt = 0;
    spi_frame(16'h2000, 16, 1'b1, w);
    idle(20);
    checks++; if (w !== 16'h0000) begin errors++; $display("FAIL two_frame_w1 got=%h exp=0000", w); end
    checks++; if (chnnl !== 3'd4) begin errors++; $display("FAIL two_frame_ch1 got=%0d exp=4", chnnl); end
    spi_frame(16'h0001, 16, 1'b1, w);
    idle(20);
    checks++; if (w !== 16'h0A5C) begin errors++; $display("FAIL two_frame_w2 got=%h exp=0a5c", w); end
    checks++; if (chnnl !== 3'd0) begin errors++; $display("FAIL two_frame_ch2 got=%0d exp=0", chnnl); end
    checks++; if (td_cnt !== 2) begin errors++; $display("FAIL two_frame_td got=%0d exp=2", td_cnt); end
  endtask

  task automatic test_round_robin;
    logic [15:0] w;
    logic [15:0] cmds [4];
    logic [15:0] exp_w [4];
    cmds  = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};
    exp_w = '{16'h0000, 16'h0100, 16'h0104, 16'h0105};
    res_mode = 1'b1;
    for (int f = 0; f < 4; f++) begin
      spi_frame(cmds[f], 16, 1'b1, w);
      idle(20);
      if (f > 0) begin
        checks++;
        if (w !== exp_w[f]) begin
          errors++; $display("FAIL round_robin_f%0d got=%h exp=%h", f + 1, w, exp_w[f]);
        end
      end
    end
    checks++; if (chnnl !== 3'd6) begin errors++; $display("FAIL round_robin_ch got=%0d exp=6", chnnl); end
  endtask

  task automatic test_partial;
    logic [15:0] w;
    td_cnt = 0;
    spi_frame(16'h1000, 9, 1'b1, w);
    idle(20);
    checks++; if (chnnl !== 3'd6) begin errors++; $display("FAIL partial_ch got=%0d exp=6", chnnl); end
    checks++; if (td_cnt !== 0) begin errors++; $display("FAIL partial_td got=%0d exp=0", td_cnt); end
`ifdef A2D_RESP_ERR_EN
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL partial_err got=%b exp=1", err); end
`endif
    spi_frame(16'h1000, 16, 1'b1, w);
    idle(20);
    checks++; if (w !== 16'h0106) begin errors++; $display("FAIL partial_next_w got=%h exp=0106", w); end
    checks++; if (chnnl !== 3'd2) begin errors++; $display("FAIL partial_next_ch got=%0d exp=2", chnnl); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] wa, wb;
    td_cnt = 0;
    spi_frame(16'h1800, 16, 1'b1, wa);
    spi_frame(16'h0800, 16, 1'b1, wb);
    idle(20);
    checks++; if (wa !== 16'h0102) begin errors++; $display("FAIL b2b_wa got=%h exp=0102", wa); end
    checks++; if (wb !== 16'h0103) begin errors++; $display("FAIL b2b_wb got=%h exp=0103", wb); end
    checks++; if (chnnl !== 3'd1) begin errors++; $display("FAIL b2b_ch got=%0d exp=1", chnnl); end
    checks++; if (td_cnt !== 2) begin errors++; $display("FAIL b2b_td got=%0d exp=2", td_cnt); end
  endtask

  task automatic test_mid_reset;
    logic [15:0] w;
    spi_frame(16'hFFFF, 7, 1'b0, w);
    rst_n = 1'b0;
    idle(2);
    td_cnt = 0;
    ss_n = 1'b1;
    sclk = 1'b1;
    idle(2);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL midrst_miso got=%b exp=0", miso); end
    checks++; if (chnnl !== 3'd0) begin errors++; $display("FAIL midrst_ch got=%0d exp=0", chnnl); end
`ifdef A2D_RESP_ERR_EN
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err got=%b exp=0", err); end
`endif
    rst_n = 1'b1;
    idle(4);
    spi_frame(16'h3000, 16, 1'b1, w);
    idle(20);
    checks++; if (w !== 16'h0000) begin errors++; $display("FAIL midrst_w got=%h exp=0000", w); end
    checks++; if (chnnl !== 3'd6) begin errors++; $display("FAIL midrst_next_ch got=%0d exp=6", chnnl); end
    checks++; if (td_cnt !== 1) begin errors++; $display("FAIL midrst_td got=%0d exp=1", td_cnt); end
  endtask

  initial begin
    test_reset();
    test_two_frame();
    test_round_robin();
    test_partial();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
